// File: rtl/dtw_dispatch_if.sv
// dtw_dispatch_if: bundles the dispatcher's upstream, per-core and downstream
// signals.
//   master : the dispatcher (drives pops, core strobes and the downstream write)
//   slave  : the surrounding FIFOs and cores
// Parameters: NUM_CORES (core count), AXIS_WIDTH (data word width).
interface dtw_dispatch_if #(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned AXIS_WIDTH = 32
);
  // Control / status
  logic                            ref_load_start;
  logic [AXIS_WIDTH-1:0]           ref_len;
  logic                            ref_loaded;
  logic                            busy;
  // Upstream (DMA-side source FIFO, FWFT)
  logic                            up_rden;
  logic                            up_empty;
  logic [AXIS_WIDTH-1:0]           up_data;
  // Core control
  logic [NUM_CORES-1:0]            core_rs;
  logic                            core_op_mode;
  logic [NUM_CORES-1:0]            core_busy;
  logic [NUM_CORES-1:0]            core_load_done;
  // Per-core source FIFOs
  logic [NUM_CORES-1:0]            core_src_wren;
  logic [NUM_CORES-1:0]            core_src_full;
  logic [AXIS_WIDTH-1:0]           core_src_data;
  // Per-core sink FIFOs (FWFT)
  logic [NUM_CORES-1:0]            core_sink_rden;
  logic [NUM_CORES-1:0]            core_sink_empty;
  logic [NUM_CORES*AXIS_WIDTH-1:0] core_sink_data;
  // Downstream (DMA-side sink FIFO)
  logic                            dn_wren;
  logic                            dn_full;
  logic [AXIS_WIDTH-1:0]           dn_data;
  logic                            dn_last;

  modport master (
    input  ref_load_start, ref_len, up_empty, up_data, core_busy, core_load_done,
           core_src_full, core_sink_empty, core_sink_data, dn_full,
    output ref_loaded, busy, up_rden, core_rs, core_op_mode, core_src_wren,
           core_src_data, core_sink_rden, dn_wren, dn_data, dn_last
  );

  modport slave (
    output ref_load_start, ref_len, up_empty, up_data, core_busy, core_load_done,
           core_src_full, core_sink_empty, core_sink_data, dn_full,
    input  ref_loaded, busy, up_rden, core_rs, core_op_mode, core_src_wren,
           core_src_data, core_sink_rden, dn_wren, dn_data, dn_last
  );
endinterface

// File: rtl/dtw_dispatch.sv
// dtw_dispatch: shares a bank of dtw_core instances between one upstream query
// stream and one downstream result stream.
//   - Reference load: broadcasts ref_len words to every core.
//   - Normal mode: hands each query (qid + SQG_SIZE samples) to an idle core
//     (round-robin) and drains RESULT_WORDS-word result records from the cores
//     into the shared downstream FIFO (round-robin, never interleaved).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dtw_dispatch_if.master (control, upstream, per-core, downstream)
// Optional (macro DTW_DISPATCH_STATS_EN):
//   dbg_nq_in    : count of completed query transfers (wraps at 2^32)
//   dbg_nres_out : count of result records written downstream (wraps at 2^32)
module dtw_dispatch #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned AXIS_WIDTH   = 32,
  parameter int unsigned SQG_SIZE     = 250,
  parameter int unsigned RESULT_WORDS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dtw_dispatch_if.master       bus
`ifdef DTW_DISPATCH_STATS_EN
  ,
  output logic [31:0]          dbg_nq_in,
  output logic [31:0]          dbg_nres_out
`endif
);

  localparam int unsigned IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned RCNT_W = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1;

  typedef enum logic [2:0] {
    D_IDLE,
    D_REF_START,
    D_REF_XFER,
    D_REF_WAIT,
    D_PICK,
    D_Q_START,
    D_Q_XFER
  } dstate_e;

  typedef enum logic {
    C_SCAN,
    C_XFER
  } cstate_e;

  dstate_e               dstate_q, dstate_d;
  logic [AXIS_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      tgt_q, tgt_d;
  logic                  ref_loaded_q, ref_loaded_d;

  cstate_e               cstate_q, cstate_d;
  logic [IDX_W-1:0]      crr_q, crr_d;
  logic [IDX_W-1:0]      csel_q, csel_d;
  logic [RCNT_W-1:0]     ccnt_q, ccnt_d;

  // (base + off) mod NUM_CORES, off < NUM_CORES
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_CORES) s = s - NUM_CORES;
    return IDX_W'(s);
  endfunction

  // Round-robin searches: first idle core from rr_q, first non-empty sink from crr_q
  logic             idle_found, sink_found;
  logic [IDX_W-1:0] idle_idx, sink_idx;

  always_comb begin
    idle_found = 1'b0;
    idle_idx   = '0;
    sink_found = 1'b0;
    sink_idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!idle_found && !bus.core_busy[wrap_add(rr_q, i)]) begin
        idle_found = 1'b1;
        idle_idx   = wrap_add(rr_q, i);
      end
      if (!sink_found && !bus.core_sink_empty[wrap_add(crr_q, i)]) begin
        sink_found = 1'b1;
        sink_idx   = wrap_add(crr_q, i);
      end
    end
  end

  // Zero-latency forwarding strobes
  logic ref_xfer_act, ref_beat, q_beat, q_done, c_beat, c_last;

  assign ref_xfer_act = (dstate_q == D_REF_XFER) && (dcnt_q != bus.ref_len);
  assign ref_beat     = ref_xfer_act && !bus.up_empty && !(|bus.core_src_full);
  assign q_beat       = (dstate_q == D_Q_XFER) && !bus.up_empty && !bus.core_src_full[tgt_q];
  assign q_done       = q_beat && (dcnt_q == AXIS_WIDTH'(SQG_SIZE));
  assign c_beat       = (cstate_q == C_XFER) && !bus.core_sink_empty[csel_q] && !bus.dn_full;
  assign c_last       = (ccnt_q == RCNT_W'(RESULT_WORDS - 1));

  assign bus.up_rden        = ref_beat | q_beat;
  assign bus.core_src_wren  = ref_beat ? {NUM_CORES{1'b1}} :
                              (q_beat ? (NUM_CORES'(1) << tgt_q) : '0);
  assign bus.core_src_data  = bus.up_data;
  assign bus.core_rs        = (dstate_q == D_REF_START) ? {NUM_CORES{1'b1}} :
                              ((dstate_q == D_Q_START) ? (NUM_CORES'(1) << tgt_q) : '0);
  assign bus.core_op_mode   = (dstate_q == D_REF_START) || (dstate_q == D_REF_XFER) ||
                              (dstate_q == D_REF_WAIT);
  assign bus.core_sink_rden = c_beat ? (NUM_CORES'(1) << csel_q) : '0;
  assign bus.dn_wren        = c_beat;
  assign bus.dn_data        = (cstate_q == C_XFER) ?
                              bus.core_sink_data[32'(csel_q) * AXIS_WIDTH +: AXIS_WIDTH] : '0;
  assign bus.dn_last        = c_beat && c_last;
  assign bus.ref_loaded     = ref_loaded_q;
  assign bus.busy           = (dstate_q != D_IDLE) || (cstate_q != C_SCAN) || (|bus.core_busy);

  // Dispatch next-state
  always_comb begin
    dstate_d     = dstate_q;
    dcnt_d       = dcnt_q;
    rr_d         = rr_q;
    tgt_d        = tgt_q;
    ref_loaded_d = ref_loaded_q;
    case (dstate_q)
      D_IDLE: begin
        // A load request after the reference is already loaded is ignored
        if (bus.ref_load_start && !ref_loaded_q) dstate_d = D_REF_START;
        else if (ref_loaded_q && !bus.up_empty)  dstate_d = D_PICK;
      end
      D_REF_START: begin
        if (&bus.core_busy) begin
          dstate_d = D_REF_XFER;
          dcnt_d   = '0;
        end
      end
      D_REF_XFER: begin
        if (!ref_xfer_act) begin
          dstate_d = D_REF_WAIT;
        end else if (ref_beat) begin
          dcnt_d = dcnt_q + AXIS_WIDTH'(1);
          if (dcnt_d == bus.ref_len) dstate_d = D_REF_WAIT;
        end
      end
      D_REF_WAIT: begin
        if (&bus.core_load_done) begin
          ref_loaded_d = 1'b1;
          dstate_d     = D_IDLE;
        end
      end
      D_PICK: begin
        if (idle_found) begin
          tgt_d    = idle_idx;
          rr_d     = wrap_add(idle_idx, 1);
          dstate_d = D_Q_START;
        end
      end
      D_Q_START: begin
        // Core clears its source FIFO while idle, so nothing is written yet
        if (bus.core_busy[tgt_q]) begin
          dstate_d = D_Q_XFER;
          dcnt_d   = '0;
        end
      end
      D_Q_XFER: begin
        if (q_beat) begin
          dcnt_d = dcnt_q + AXIS_WIDTH'(1);
          if (q_done) dstate_d = D_IDLE;
        end
      end
      default: dstate_d = D_IDLE;
    endcase
  end

  // Collect next-state: a locked core keeps the downstream until its record ends
  always_comb begin
    cstate_d = cstate_q;
    crr_d    = crr_q;
    csel_d   = csel_q;
    ccnt_d   = ccnt_q;
    case (cstate_q)
      C_SCAN: begin
        if (sink_found) begin
          csel_d   = sink_idx;
          crr_d    = wrap_add(sink_idx, 1);
          ccnt_d   = '0;
          cstate_d = C_XFER;
        end
      end
      C_XFER: begin
        if (c_beat) begin
          if (c_last) cstate_d = C_SCAN;
          else        ccnt_d   = ccnt_q + RCNT_W'(1);
        end
      end
      default: cstate_d = C_SCAN;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstate_q     <= D_IDLE;
      dcnt_q       <= '0;
      rr_q         <= '0;
      tgt_q        <= '0;
      ref_loaded_q <= 1'b0;
      cstate_q     <= C_SCAN;
      crr_q        <= '0;
      csel_q       <= '0;
      ccnt_q       <= '0;
    end else begin
      dstate_q     <= dstate_d;
      dcnt_q       <= dcnt_d;
      rr_q         <= rr_d;
      tgt_q        <= tgt_d;
      ref_loaded_q <= ref_loaded_d;
      cstate_q     <= cstate_d;
      crr_q        <= crr_d;
      csel_q       <= csel_d;
      ccnt_q       <= ccnt_d;
    end
  end

`ifdef DTW_DISPATCH_STATS_EN
  // Debug event counters
  logic [31:0] nq_in_q, nres_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nq_in_q    <= '0;
      nres_out_q <= '0;
    end else begin
      if (q_done)                   nq_in_q    <= nq_in_q + 32'd1;
      if (c_beat && c_last)         nres_out_q <= nres_out_q + 32'd1;
    end
  end

  assign dbg_nq_in    = nq_in_q;
  assign dbg_nres_out = nres_out_q;
`endif

endmodule

// File: tb/tb_dtw_dispatch.sv
// tb_dtw_dispatch: directed bench for dtw_dispatch with FIFO/core models.
module tb_dtw_dispatch;
  localparam int NC  = 4;
  localparam int AW  = 32;
  localparam int SQG = 4;
  localparam int RW  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dtw_dispatch_if #(.NUM_CORES(NC), .AXIS_WIDTH(AW)) bus ();

`ifdef DTW_DISPATCH_STATS_EN
  logic [31:0] dbg_nq_in, dbg_nres_out;
`endif

  dtw_dispatch #(
    .NUM_CORES(NC), .AXIS_WIDTH(AW), .SQG_SIZE(SQG), .RESULT_WORDS(RW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef DTW_DISPATCH_STATS_EN
    ,
    .dbg_nq_in(dbg_nq_in),
    .dbg_nres_out(dbg_nres_out)
`endif
  );

  int n_pass   = 0;
  int n_checks = 0;

  // Stimulus drivers
  logic          rls_t       = 1'b0;
  logic [31:0]   ref_len_t   = '0;
  logic          up_gate     = 1'b0;
  logic [NC-1:0] full_t      = '0;
  logic          dn_full_t   = 1'b0;
  logic [NC-1:0] release_t   = '0;
  logic [NC-1:0] load_done_t = '0;

  assign bus.ref_load_start = rls_t;
  assign bus.ref_len        = ref_len_t;
  assign bus.core_src_full  = full_t;
  assign bus.dn_full        = dn_full_t;
  assign bus.core_load_done = load_done_t;

  // Upstream FWFT FIFO model
  logic [31:0] up_mem [64];
  int up_wr = 0;
  int up_rd = 0;
  assign bus.up_empty = (up_rd == up_wr) | up_gate;
  assign bus.up_data  = up_mem[up_rd[5:0]];
  always @(posedge clk) if (bus.up_rden) up_rd <= up_rd + 1;

  // Per-core source FIFO capture
  logic [31:0] cap_mem [NC][64];
  int cap_cnt [NC] = '{0, 0, 0, 0};
  always @(posedge clk)
    for (int i = 0; i < NC; i++)
      if (bus.core_src_wren[i]) begin
        cap_mem[i][cap_cnt[i][5:0]] <= bus.core_src_data;
        cap_cnt[i] <= cap_cnt[i] + 1;
      end

  // Per-core sink FIFO models
  logic [31:0] sink_mem [NC][8];
  int sink_wr [NC] = '{0, 0, 0, 0};
  int sink_rd [NC] = '{0, 0, 0, 0};
  for (genvar g = 0; g < NC; g++) begin : g_sink
    assign bus.core_sink_empty[g]        = (sink_rd[g] == sink_wr[g]);
    assign bus.core_sink_data[g*AW +: AW] = sink_mem[g][sink_rd[g][2:0]];
  end
  always @(posedge clk)
    for (int i = 0; i < NC; i++)
      if (bus.core_sink_rden[i]) sink_rd[i] <= sink_rd[i] + 1;

  // Downstream capture {last, data}
  logic [32:0] dn_mem [16];
  int dn_cnt = 0;
  always @(posedge clk)
    if (bus.dn_wren) begin
      dn_mem[dn_cnt[3:0]] <= {bus.dn_last, bus.dn_data};
      dn_cnt <= dn_cnt + 1;
    end

  // Core busy model: goes busy on run-start, idles on release; resets with the design
  logic [NC-1:0] busy_r;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) busy_r <= '0;
    else        busy_r <= (busy_r | bus.core_rs) & ~release_t;
  assign bus.core_busy = busy_r;

  task automatic push(input logic [31:0] w);
    up_mem[up_wr[5:0]] = w;
    up_wr = up_wr + 1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.ref_loaded !== 1'b0) $display("FAIL reset_ref_loaded got=%b exp=0", bus.ref_loaded); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
    n_checks++; if (bus.core_rs !== 4'h0) $display("FAIL reset_core_rs got=%h exp=0", bus.core_rs); else n_pass++;
    n_checks++; if (bus.core_op_mode !== 1'b0) $display("FAIL reset_op_mode got=%b exp=0", bus.core_op_mode); else n_pass++;
    n_checks++; if ({bus.up_rden, bus.core_src_wren, bus.core_sink_rden, bus.dn_wren, bus.dn_last} !== 11'h0)
      $display("FAIL reset_strobes got=%h exp=0", {bus.up_rden, bus.core_src_wren, bus.core_sink_rden, bus.dn_wren, bus.dn_last});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ref_load();
    int b[NC];
    int stall_bad = 0;
    int stall_seen = 0;
    bit done = 0;
    for (int k = 0; k < 8; k++) push(32'hA0 + k);
    for (int i = 0; i < NC; i++) b[i] = cap_cnt[i];
    ref_len_t = 32'd8;
    up_gate   = 1'b1;
    rls_t     = 1'b1;
    @(negedge clk);
    rls_t = 1'b0;
    n_checks++; if ({bus.core_op_mode, bus.core_rs} !== 5'h1F)
      $display("FAIL ref_start got op=%b rs=%h exp op=1 rs=f", bus.core_op_mode, bus.core_rs); else n_pass++;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      up_gate = c[0];
      full_t  = (c >= 6 && c < 11) ? 4'b0100 : 4'b0000;
      #1;
      if (full_t != 0) begin
        stall_seen++;
        if (bus.up_rden || bus.core_src_wren != 0) stall_bad++;
      end
      done = 1;
      for (int i = 0; i < NC; i++) if (cap_cnt[i] - b[i] < 8) done = 0;
    end
    full_t  = '0;
    up_gate = 1'b0;
    n_checks++; if (!done) $display("FAIL ref_timeout got=not_done exp=done"); else n_pass++;
    n_checks++; if (stall_bad !== 0 || stall_seen !== 5)
      $display("FAIL ref_full_stall got bad=%0d seen=%0d exp bad=0 seen=5", stall_bad, stall_seen); else n_pass++;
    for (int i = 0; i < NC; i++) begin
      bit ok = (cap_cnt[i] - b[i] == 8);
      for (int k = 0; k < 8; k++) if (cap_mem[i][b[i] + k] !== 32'hA0 + k) ok = 0;
      n_checks++; if (!ok) $display("FAIL ref_words core=%0d got cnt=%0d exp cnt=8 data A0..A7", i, cap_cnt[i] - b[i]); else n_pass++;
    end
    n_checks++; if (up_rd !== up_wr) $display("FAIL ref_pops got=%0d exp=%0d", up_rd, up_wr); else n_pass++;
    @(negedge clk);
    n_checks++; if ({bus.ref_loaded, bus.core_rs} !== 5'h0)
      $display("FAIL ref_wait got loaded=%b rs=%h exp 0/0", bus.ref_loaded, bus.core_rs); else n_pass++;
    load_done_t = 4'hF;
    release_t   = 4'hF;
    @(negedge clk);
    release_t = '0;
    n_checks++; if (bus.ref_loaded !== 1'b1) $display("FAIL ref_loaded got=%b exp=1", bus.ref_loaded); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL ref_idle_busy got=%b exp=0", bus.busy); else n_pass++;
    rls_t = 1'b1;
    @(negedge clk);
    rls_t = 1'b0;
    n_checks++; if ({bus.core_op_mode, bus.core_rs, bus.busy} !== 6'h0)
      $display("FAIL ref_reload_ignored got op=%b rs=%h busy=%b exp 0", bus.core_op_mode, bus.core_rs, bus.busy); else n_pass++;
  endtask

  task automatic test_dispatch();
    int b[NC];
    bit done = 0;
    for (int i = 0; i < NC; i++) b[i] = cap_cnt[i];
    for (int q = 0; q < 4; q++) begin
      push(32'(10 + q));
      for (int s = 0; s < SQG; s++) push(32'h100 * (q + 1) + s);
    end
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = 1;
      for (int i = 0; i < NC; i++) if (cap_cnt[i] - b[i] < SQG + 1) done = 0;
    end
    repeat (4) @(negedge clk);
    n_checks++; if (!done) $display("FAIL dispatch_timeout got=not_done exp=done"); else n_pass++;
    for (int i = 0; i < NC; i++) begin
      bit ok = (cap_cnt[i] - b[i] == SQG + 1) && (cap_mem[i][b[i]] === 32'(10 + i));
      for (int s = 0; s < SQG; s++) if (cap_mem[i][b[i] + 1 + s] !== 32'h100 * (i + 1) + s) ok = 0;
      n_checks++; if (!ok) $display("FAIL dispatch_core%0d got cnt=%0d qid=%0d exp cnt=5 qid=%0d", i, cap_cnt[i] - b[i], cap_mem[i][b[i]], 10 + i); else n_pass++;
    end
  endtask

  task automatic test_all_busy();
    int b[NC];
    int bad = 0;
    bit done = 0;
    bit ok;
    for (int i = 0; i < NC; i++) b[i] = cap_cnt[i];
    push(32'd20);
    for (int s = 0; s < SQG; s++) push(32'h500 + s);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (bus.up_rden || bus.core_rs != 0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL busy_no_read got=%0d exp=0", bad); else n_pass++;
    release_t = 4'b0010;
    @(negedge clk);
    release_t = '0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = (cap_cnt[1] - b[1] >= SQG + 1);
    end
    ok = done && (cap_mem[1][b[1]] === 32'd20);
    for (int s = 0; s < SQG; s++) if (cap_mem[1][b[1] + 1 + s] !== 32'h500 + s) ok = 0;
    n_checks++; if (!ok) $display("FAIL busy_core1 got cnt=%0d qid=%0d exp cnt=5 qid=20", cap_cnt[1] - b[1], cap_mem[1][b[1]]); else n_pass++;
    n_checks++; if ((cap_cnt[0] - b[0]) + (cap_cnt[2] - b[2]) + (cap_cnt[3] - b[3]) !== 0)
      $display("FAIL busy_others got=%0d exp=0", (cap_cnt[0] - b[0]) + (cap_cnt[2] - b[2]) + (cap_cnt[3] - b[3])); else n_pass++;
  endtask

  task automatic test_collect();
    logic [32:0] exp_w [6];
    int db;
    int hold = 0;
    int bad = 0;
    exp_w = '{{1'b0, 32'h1000}, {1'b0, 32'h1001}, {1'b1, 32'h1002},
              {1'b0, 32'h3000}, {1'b0, 32'h3001}, {1'b1, 32'h3002}};
    db = dn_cnt;
    for (int k = 0; k < 3; k++) begin
      sink_mem[0][k] = 32'h1000 + k;
      sink_mem[3][k] = 32'h3000 + k;
    end
    sink_wr[0] = 3;
    sink_wr[3] = 3;
    for (int c = 0; c < 100 && (dn_cnt - db) < 6; c++) begin
      @(negedge clk);
      dn_full_t = (dn_cnt - db == 1) && (hold < 3);
      if (dn_full_t) hold++;
      #1;
      if (dn_full_t && (bus.dn_wren || bus.core_sink_rden != 0)) bad++;
    end
    dn_full_t = 1'b0;
    n_checks++; if (bad !== 0 || hold !== 3) $display("FAIL collect_stall got bad=%0d hold=%0d exp 0/3", bad, hold); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (dn_mem[(db + k) % 16] !== exp_w[k])
        $display("FAIL collect_word%0d got=%h exp=%h", k, dn_mem[(db + k) % 16], exp_w[k]); else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (bus.dn_wren !== 1'b0) $display("FAIL collect_done got=%b exp=0", bus.dn_wren); else n_pass++;
`ifdef DTW_DISPATCH_STATS_EN
    n_checks++; if (dbg_nq_in !== 32'd5 || dbg_nres_out !== 32'd2)
      $display("FAIL stats got q=%0d r=%0d exp 5/2", dbg_nq_in, dbg_nres_out); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_xfer();
    int base;
    int bad = 0;
    bit hit = 0;
    release_t = 4'hF;
    @(negedge clk);
    release_t = '0;
    base = cap_cnt[0] + cap_cnt[1] + cap_cnt[2] + cap_cnt[3];
    push(32'd30);
    for (int s = 0; s < SQG; s++) push(32'h700 + s);
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      hit = (cap_cnt[0] + cap_cnt[1] + cap_cnt[2] + cap_cnt[3] - base >= 2);
    end
    n_checks++; if (!hit) $display("FAIL rst_mid_timeout got=not_started exp=started"); else n_pass++;
    rst_n       = 1'b0;
    load_done_t = '0;
    #1;
    n_checks++; if ({bus.up_rden, bus.core_src_wren, bus.core_rs} !== 9'h0)
      $display("FAIL rst_mid_strobes got=%h exp=0", {bus.up_rden, bus.core_src_wren, bus.core_rs}); else n_pass++;
    n_checks++; if ({bus.ref_loaded, bus.busy, bus.core_op_mode} !== 3'b000)
      $display("FAIL rst_mid_status got=%b exp=000", {bus.ref_loaded, bus.busy, bus.core_op_mode}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      if (bus.up_rden || bus.core_rs != 0) bad++;
    end
    n_checks++; if (bad !== 0 || bus.up_empty !== 1'b0)
      $display("FAIL rst_no_dispatch got bad=%0d empty=%b exp 0/0", bad, bus.up_empty); else n_pass++;
    n_checks++; if (bus.ref_loaded !== 1'b0) $display("FAIL rst_ref_loaded got=%b exp=0", bus.ref_loaded); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ref_load();
    test_dispatch();
    test_all_busy();
    test_collect();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
